core4_cpu_1_oci_dct_packer: RTL and testbench

- Producer side of the OCI data-cycle-trace (DCT) frame interface.
- Packs 2-bit trace atoms from the CPU trace logic into 30-bit frames (`dct_buffer`) with an atom count (`dct_count`).
- Presents frames over a valid/ready handshake to the trace sink (on-chip trace memory or simulation test bench).
- Sequences end-of-test draining and raises `test_ending` / `test_has_ended` for the sink.

---
 rtl/core4_cpu_1_oci_pkg.sv | 26 ++
 rtl/core4_cpu_1_oci_dct_outreg.sv | 28 ++
 rtl/core4_cpu_1_oci_dct_packer.sv | 99 +++++++++
 tb/tb_core4_cpu_1_oci_dct_packer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/core4_cpu_1_oci_pkg.sv
// Shared definitions for the OCI trace blocks: frame geometry, drain states
// and atom codes.
package core4_cpu_1_oci_pkg;
  localparam int ATOM_W          = 2;
  localparam int ATOMS_PER_FRAME = 15;
  localparam int CNT_W           = 4;
  localparam int FRAME_W         = ATOM_W * ATOMS_PER_FRAME;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  typedef enum logic [ATOM_W-1:0] {
    ATOM_NOP  = 2'd0,
    ATOM_LD   = 2'd1,
    ATOM_ST   = 2'd2,
    ATOM_MARK = 2'd3
  } atom_code_e;

  typedef struct packed {
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] data;
  } dct_frame_t;
endpackage

// File: rtl/core4_cpu_1_oci_dct_outreg.sv
// Single-entry valid/ready holding register; payload is held stable until
// the sink takes it, and a new word may load in the same cycle it drains.
module core4_cpu_1_oci_dct_outreg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/core4_cpu_1_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom DCT frames, hands them to the sink over
// valid/ready, and sequences the end-of-test drain.
module core4_cpu_1_oci_dct_packer
  import core4_cpu_1_oci_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                atom_valid,
  input  logic [ATOM_W-1:0]   atom,
  output logic                atom_ready,
  input  logic                flush,
  input  logic                end_req,
  output logic                dct_valid,
  input  logic                dct_ready,
  output logic [FRAME_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]    dct_count,
  output logic                test_ending,
  output logic                test_has_ended,
  output logic [7:0]          drop_cnt
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS_PER_FRAME);

  drain_state_e       state, state_nxt;
  logic [FRAME_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   acc_cnt, cnt_nxt;
  logic               flush_pend, flush_req, accept, launch_req, launch;
  logic               out_full, in_ready;
  dct_frame_t         frame_in, frame_out;

  always_comb begin
    atom_ready = (state == RUN) && !(acc_cnt == FULL && out_full);
    accept     = atom_valid && atom_ready;
    acc_nxt    = acc;
    cnt_nxt    = acc_cnt;
    if (accept) begin
      acc_nxt[ATOM_W*acc_cnt +: ATOM_W] = atom;
      cnt_nxt = acc_cnt + 4'd1;
    end
    // DRAIN keeps pushing whatever is left; entering DRAIN acts as a flush.
    flush_req  = flush || flush_pend || (state == RUN && end_req) || (state == DRAIN);
    launch_req = (cnt_nxt == FULL) || (flush_req && cnt_nxt != '0);
    launch     = launch_req && in_ready;
    frame_in   = '{cnt: cnt_nxt, data: acc_nxt};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (launch) begin
        acc        <= '0;
        acc_cnt    <= '0;
        flush_pend <= 1'b0;
      end else begin
        acc        <= acc_nxt;
        acc_cnt    <= cnt_nxt;
        flush_pend <= flush_req && (state != DRAIN) && (cnt_nxt != '0);
      end
      if (state == RUN && atom_valid && !atom_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (end_req) state_nxt = DRAIN;
      DRAIN:   if (acc_cnt == '0 && !flush_pend && (!out_full || dct_ready)) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign test_ending    = (state == DRAIN);
  assign test_has_ended = (state == DONE);

  core4_cpu_1_oci_dct_outreg #(.W($bits(dct_frame_t))) u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (launch_req),
    .in_data   (frame_in),
    .in_ready  (in_ready),
    .out_valid (out_full),
    .out_data  (frame_out),
    .out_ready (dct_ready)
  );

  assign dct_valid  = out_full;
  assign dct_buffer = frame_out.data;
  assign dct_count  = frame_out.cnt;
endmodule

// File: tb/tb_core4_cpu_1_oci_dct_packer.sv
// Directed bench for the DCT packer: framing, flush, backpressure, drain, reset.
module tb_core4_cpu_1_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset_n, atom_valid, flush, end_req, dct_ready;
  logic [1:0]  atom;
  logic        atom_ready, dct_valid, test_ending, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  core4_cpu_1_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom),
    .atom_ready(atom_ready), .flush(flush), .end_req(end_req),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] a, input logic fl);
    atom_valid = 1'b1; atom = a; flush = fl;
    tick();
    atom_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(); tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", dct_valid); end
    n_checks++; if (dct_buffer !== 30'h0) begin n_fail++; $display("FAIL rst_buffer: got %h want 0", dct_buffer); end
    n_checks++; if (dct_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", dct_count); end
    n_checks++; if ({test_ending, test_has_ended} !== 2'b00) begin n_fail++; $display("FAIL rst_test_flags: got %b want 00", {test_ending, test_has_ended}); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    n_checks++; if (atom_ready !== 1'b1) begin n_fail++; $display("FAIL rst_atom_ready: got %0b want 1", atom_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_full_frame();
    dct_ready = 1'b1;
    for (int i = 0; i < 14; i++) send(2'b01, 1'b0);
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %0b want 0", dct_valid); end
    send(2'b01, 1'b0);
    n_checks++; if (dct_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %0b want 1", dct_valid); end
    n_checks++; if (dct_buffer !== 30'h15555555) begin n_fail++; $display("FAIL full_buffer: got %h want 15555555", dct_buffer); end
    n_checks++; if (dct_count !== 4'd15) begin n_fail++; $display("FAIL full_count: got %0d want 15", dct_count); end
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %0b want 0", dct_valid); end
  endtask

  task automatic test_back_to_back();
    logic ready_seen = 1'b1;
    dct_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ready_seen &= atom_ready;
      send(2'(i % 4), 1'b0);
      if (i == 14) begin
        n_checks++; if (dct_buffer !== 30'h24E4E4E4 || dct_count !== 4'd15 || dct_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_frame0: got v=%0b %h/%0d want 1 24e4e4e4/15", dct_valid, dct_buffer, dct_count); end
      end
      if (i == 15) begin
        n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %0b want 0", dct_valid); end
      end
    end
    n_checks++; if (dct_buffer !== 30'h13939393 || dct_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_frame1: got v=%0b %h want 1 13939393", dct_valid, dct_buffer); end
    n_checks++; if (ready_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_atom_ready: got %0b want 1", ready_seen); end
    tick();
  endtask

  task automatic test_flush();
    dct_ready = 1'b1;
    send(2'd3, 1'b0); send(2'd2, 1'b0); send(2'd1, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h0000001B) begin n_fail++; $display("FAIL flush_frame: got v=%0b %h/%0d want 1 0000001b/3", dct_valid, dct_buffer, dct_count); end
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %0b want 0", dct_valid); end
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_late: got %0b want 0", dct_valid); end
  endtask

  task automatic test_backpressure();
    dct_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'd2, 1'b0);
    n_checks++; if (dct_valid !== 1'b1 || dct_buffer !== 30'h2AAAAAAA) begin n_fail++; $display("FAIL bp_first: got v=%0b %h want 1 2aaaaaaa", dct_valid, dct_buffer); end
    for (int i = 0; i < 14; i++) send(2'd3, 1'b0);
    n_checks++; if (atom_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_29: got %0b want 1", atom_ready); end
    send(2'd3, 1'b0);
    n_checks++; if (atom_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_30: got %0b want 0", atom_ready); end
    send(2'd1, 1'b0);
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop_cnt); end
    n_checks++; if (dct_buffer !== 30'h2AAAAAAA || dct_count !== 4'd15) begin n_fail++; $display("FAIL bp_stable: got %h/%0d want 2aaaaaaa/15", dct_buffer, dct_count); end
    dct_ready = 1'b1; tick();
    n_checks++; if (dct_valid !== 1'b1 || dct_buffer !== 30'h3FFFFFFF) begin n_fail++; $display("FAIL bp_second: got v=%0b %h want 1 3fffffff", dct_valid, dct_buffer); end
    n_checks++; if (atom_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0b want 1", atom_ready); end
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b want 0", dct_valid); end
  endtask

  task automatic test_flush_with_atom();
    dct_ready = 1'b1;
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0);
    send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0);
    send(2'd3, 1'b1);
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd7 || dct_buffer !== 30'h00003939) begin n_fail++; $display("FAIL flush_atom: got v=%0b %h/%0d want 1 00003939/7", dct_valid, dct_buffer, dct_count); end
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL flush_atom_once: got %0b want 0", dct_valid); end
  endtask

  task automatic test_reset_mid_frame();
    dct_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(2'd1, 1'b0);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    n_checks++; if (dct_valid !== 1'b0 || dct_buffer !== 30'h0 || dct_count !== 4'd0) begin n_fail++; $display("FAIL mid_rst_out: got v=%0b %h/%0d want 0 0/0", dct_valid, dct_buffer, dct_count); end
    n_checks++; if (atom_ready !== 1'b1 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_ready_drop: got %0b/%0d want 1/0", atom_ready, drop_cnt); end
    dct_ready = 1'b1;
    flush = 1'b1; tick(); flush = 1'b0; tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_frame: got %0b want 0", dct_valid); end
  endtask

  task automatic test_drain();
    dct_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd2, 1'b0);
    end_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (test_ending !== 1'b1 || atom_ready !== 1'b0 || dct_valid !== 1'b1 || dct_count !== 4'd5 || dct_buffer !== 30'h2AA) begin n_fail++; $display("FAIL drain_hold_%0d: got te=%0b rdy=%0b v=%0b %h/%0d want 1 0 1 2aa/5", c, test_ending, atom_ready, dct_valid, dct_buffer, dct_count); end
    end
    dct_ready = 1'b1; tick();
    n_checks++; if (test_ending !== 1'b0 || test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin n_fail++; $display("FAIL drain_done: got te=%0b the=%0b v=%0b want 0 1 0", test_ending, test_has_ended, dct_valid); end
    end_req = 1'b0;
    send(2'd1, 1'b0); tick();
    n_checks++; if (test_has_ended !== 1'b1 || atom_ready !== 1'b0 || drop_cnt !== 8'd0 || dct_valid !== 1'b0) begin n_fail++; $display("FAIL drain_sticky: got the=%0b rdy=%0b drop=%0d v=%0b want 1 0 0 0", test_has_ended, atom_ready, drop_cnt, dct_valid); end
  endtask

  initial begin
    reset_n = 1'b0; atom_valid = 1'b0; atom = 2'd0; flush = 1'b0;
    end_req = 1'b0; dct_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_flush_with_atom();
    test_reset_mid_frame();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
